pic_cmd_uart_rx: RTL and testbench

//   Serial command receiver feeding the PIC command path: deserialises host UART bytes on clk_24m
//   and presents each byte as pic_data with a one-cycle pic_ready strobe.
//   pic_data/pic_ready drive the write side of the PIC command FIFO directly, with no extra staging.

---
 rtl/pic_cmd_uart_rx.sv | 246 ++++++++++++++++++++++++
 tb/tb_pic_cmd_uart_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pic_cmd_uart_rx.sv
// pic_cmd_uart_rx: 16x oversampled UART receiver that feeds bytes into the PIC command FIFO.
// Latency: the strobe is registered and rises 1 clk_24m after the stop-bit majority decision.
// Backpressure: none. Every pic_ready strobe must be accepted downstream, and FIFO full is ignored.
//
// Ports:
//   clk_24m    : system clock, rising edge
//   rst        : synchronous reset, active-high
//   uart_rx    : asynchronous serial input, idle high
//   pic_data   : last accepted byte; held until the next good frame
//   pic_ready  : 1-cycle strobe, pic_data valid (FIFO wr_en)
//   frame_err  : 1-cycle strobe, stop bit sampled low
//   parity_err : 1-cycle strobe, parity mismatch (tied 0 unless PIC_RX_PARITY_EN)
//   rx_busy    : high from start-bit validation until the FSM returns to IDLE
// Build option: define PIC_RX_PARITY_EN for 8 data + parity + stop frames (PARITY_ODD picks sense).
module pic_cmd_uart_rx #(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV        = CLK_HZ / (BAUD * OVERSAMPLE),
  parameter int PARITY_ODD = 0
) (
  input  logic       clk_24m,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] pic_data,
  output logic       pic_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [SAMP_W-1:0] SAMP_7    = SAMP_W'(7);
  localparam logic [SAMP_W-1:0] SAMP_8    = SAMP_W'(8);
  localparam logic [SAMP_W-1:0] SAMP_9    = SAMP_W'(9);
`ifdef PIC_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef PIC_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t            state_q, state_d;
  logic              rx_meta_q, rx_meta_d;
  logic              rx_s_q, rx_s_d;
  logic              rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [SAMP_W-1:0] samp_cnt_q, samp_cnt_d;
  logic              s7_q, s7_d;
  logic              s8_q, s8_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        pic_data_q, pic_data_d;
  logic              pic_ready_q, pic_ready_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_busy_q, rx_busy_d;
`ifdef PIC_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              parity_err_q, parity_err_d;
`endif

  logic tick;
  logic decide;
  logic maj;

  always_comb begin
    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    rx_meta_d = uart_rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;

    tick   = (div_cnt_q == DIV_LAST);
    // Majority vote uses the two stored samples and the live sample at tick 9.
    decide = tick && (samp_cnt_q == SAMP_9);
    maj    = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);

    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    samp_cnt_d = samp_cnt_q;
    if (tick) begin
      samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + 1'b1;
    end
    s7_d = (tick && samp_cnt_q == SAMP_7) ? rx_s_q : s7_q;
    s8_d = (tick && samp_cnt_q == SAMP_8) ? rx_s_q : s8_q;

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    pic_data_d  = pic_data_q;
    pic_ready_d = 1'b0;
    frame_err_d = 1'b0;
    rx_busy_d   = rx_busy_q;
`ifdef PIC_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          // Re-phase the sample grid onto the start edge.
          state_d    = ST_START;
          div_cnt_d  = '0;
          samp_cnt_d = '0;
        end
      end
      ST_START: begin
        if (decide) begin
          if (!maj) begin
            state_d   = ST_DATA;
            rx_busy_d = 1'b1;
            bit_cnt_d = '0;
`ifdef PIC_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            state_d = ST_IDLE;  // glitch: line was high again mid start bit
          end
        end
      end
      ST_DATA: begin
        if (decide) begin
          shreg_d   = {maj, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
`ifdef PIC_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef PIC_RX_PARITY_EN
      ST_PARITY: begin
        if (decide) begin
          par_bad_d = maj ^ (^shreg_q) ^ PAR_ODD;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (decide) begin
          if (maj) begin
            // Leave mid stop bit so a following start edge is not missed.
            state_d   = ST_IDLE;
            rx_busy_d = 1'b0;
`ifdef PIC_RX_PARITY_EN
            if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              pic_data_d  = shreg_q;
              pic_ready_d = 1'b1;
            end
`else
            pic_data_d  = shreg_q;
            pic_ready_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
            div_cnt_d   = '0;
            samp_cnt_d  = '0;
          end
        end
      end
      ST_BREAK: begin
        // Any low sample restarts the one-bit-time high qualification.
        if (!rx_s_q) begin
          div_cnt_d  = '0;
          samp_cnt_d = '0;
        end else if (tick && samp_cnt_q == SAMP_LAST) begin
          state_d   = ST_IDLE;
          rx_busy_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rx_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_24m) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      div_cnt_q   <= '0;
      samp_cnt_q  <= '0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      pic_data_q  <= '0;
      pic_ready_q <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
`ifdef PIC_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      div_cnt_q   <= div_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      pic_data_q  <= pic_data_d;
      pic_ready_q <= pic_ready_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
`ifdef PIC_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign pic_data  = pic_data_q;
  assign pic_ready = pic_ready_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;
`ifdef PIC_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pic_cmd_uart_rx.sv
// Directed bench for pic_cmd_uart_rx: frames are driven at 208 clocks per bit (DIV=13 x 16).
module tb_pic_cmd_uart_rx;

  localparam int BIT = 208;

  logic       clk_24m = 1'b0;
  logic       rst     = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] pic_data;
  logic       pic_ready;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  int asserts = 0;
  int fails   = 0;

  int cyc = 0;
  int rdy_cnt = 0, fe_cnt = 0, pe_cnt = 0, overlap = 0, wide = 0, busy_cnt = 0;
  int rdy_cyc = 0;
  int frame_cyc = 0;
  logic prev_rdy = 1'b0;
  logic [7:0] rx_log [$];

  pic_cmd_uart_rx dut (
    .clk_24m   (clk_24m),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .pic_data  (pic_data),
    .pic_ready (pic_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk_24m = ~clk_24m;

  always @(posedge clk_24m) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk_24m) begin
    if (pic_ready === 1'b1) begin
      rdy_cnt = rdy_cnt + 1;
      rdy_cyc = cyc;
      rx_log.push_back(pic_data);
    end
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (parity_err === 1'b1) pe_cnt = pe_cnt + 1;
    if (pic_ready === 1'b1 && (frame_err === 1'b1 || parity_err === 1'b1)) overlap = overlap + 1;
    if (pic_ready === 1'b1 && prev_rdy === 1'b1) wide = wide + 1;
    if (rx_busy === 1'b1) busy_cnt = busy_cnt + 1;
    prev_rdy = pic_ready;
  end

  task automatic hold_line(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk_24m);
  endtask

  // bad_par flips the generated even-parity bit (parity builds only).
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic bad_par);
    frame_cyc = cyc;
    hold_line(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold_line(b[i], BIT);
`ifdef PIC_RX_PARITY_EN
    hold_line((^b) ^ bad_par, BIT);
`else
    if (bad_par) hold_line(stop_v, 0);
`endif
    hold_line(stop_v, BIT);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk_24m);
    rst = 1'b0;
    asserts++; if (pic_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", pic_data); end
    asserts++; if (pic_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", pic_ready); end
    asserts++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    asserts++; if (parity_err !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    asserts++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    hold_line(1'b1, BIT);
  endtask

  task automatic test_single;
    int rb, fb, lb;
    rb = rdy_cnt; fb = fe_cnt; lb = rx_log.size();
    send_frame(8'hA5, 1'b1, 1'b0);
    hold_line(1'b1, BIT);
    asserts++; if (rdy_cnt - rb !== 1) begin fails++; $display("FAIL t1_count: got %0d want 1", rdy_cnt - rb); end
    asserts++; if (rx_log.size() <= lb || rx_log[lb] !== 8'hA5) begin fails++; $display("FAIL t1_strobe_data: log size %0d want A5", rx_log.size()); end
    asserts++; if (pic_data !== 8'hA5) begin fails++; $display("FAIL t1_held_data: got %h want a5", pic_data); end
    asserts++; if (fe_cnt - fb !== 0) begin fails++; $display("FAIL t1_ferr: got %0d want 0", fe_cnt - fb); end
    // Start edge -> sync (2) -> START (1) -> 10 ticks -> 9 more bits of 208 -> +1 register.
    asserts++; if (rdy_cyc - frame_cyc !== 2005) begin fails++; $display("FAIL t1_latency: got %0d want 2005", rdy_cyc - frame_cyc); end
    asserts++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL t1_busy_idle: got %b want 0", rx_busy); end
  endtask

  task automatic test_back_to_back;
    int rb, lb;
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h5A;
    rb = rdy_cnt; lb = rx_log.size();
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, 1'b0);
    hold_line(1'b1, BIT);
    asserts++; if (rdy_cnt - rb !== 3) begin fails++; $display("FAIL t2_count: got %0d want 3", rdy_cnt - rb); end
    for (int i = 0; i < 3; i++) begin
      asserts++;
      if (rx_log.size() <= lb + i || rx_log[lb + i] !== exp[i]) begin
        fails++; $display("FAIL t2_byte%0d: log size %0d want %h", i, rx_log.size(), exp[i]);
      end
    end
  endtask

  task automatic test_glitch;
    int rb, fb, bb;
    rb = rdy_cnt; fb = fe_cnt; bb = busy_cnt;
    hold_line(1'b0, 60);
    hold_line(1'b1, BIT);
    asserts++; if (busy_cnt - bb !== 0) begin fails++; $display("FAIL t3_busy_seen: got %0d cycles want 0", busy_cnt - bb); end
    asserts++; if (rdy_cnt - rb !== 0) begin fails++; $display("FAIL t3_ready: got %0d want 0", rdy_cnt - rb); end
    asserts++; if (fe_cnt - fb !== 0) begin fails++; $display("FAIL t3_ferr: got %0d want 0", fe_cnt - fb); end
    asserts++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL t3_busy_end: got %b want 0", rx_busy); end
  endtask

  task automatic test_frame_err;
    int rb, fb, lb;
    rb = rdy_cnt; fb = fe_cnt; lb = rx_log.size();
    send_frame(8'h3C, 1'b0, 1'b0);
    hold_line(1'b0, 3 * BIT);
    asserts++; if (fe_cnt - fb !== 1) begin fails++; $display("FAIL t4_ferr: got %0d want 1", fe_cnt - fb); end
    asserts++; if (rdy_cnt - rb !== 0) begin fails++; $display("FAIL t4_no_ready: got %0d want 0", rdy_cnt - rb); end
    asserts++; if (pic_data !== 8'h5A) begin fails++; $display("FAIL t4_data_kept: got %h want 5a", pic_data); end
    asserts++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL t4_busy_break: got %b want 1", rx_busy); end
    hold_line(1'b1, 2 * BIT);
    asserts++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL t4_break_exit: got %b want 0", rx_busy); end
    send_frame(8'h81, 1'b1, 1'b0);
    hold_line(1'b1, BIT);
    asserts++; if (rdy_cnt - rb !== 1) begin fails++; $display("FAIL t4_recover_count: got %0d want 1", rdy_cnt - rb); end
    asserts++; if (rx_log.size() <= lb || rx_log[lb] !== 8'h81) begin fails++; $display("FAIL t4_recover_data: log size %0d want 81", rx_log.size()); end
    asserts++; if (fe_cnt - fb !== 1) begin fails++; $display("FAIL t4_ferr_total: got %0d want 1", fe_cnt - fb); end
  endtask

  task automatic test_reset_midframe;
    int rb, fb, lb;
    logic [7:0] c3;
    c3 = 8'hC3;
    rb = rdy_cnt; fb = fe_cnt; lb = rx_log.size();
    hold_line(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold_line(c3[i], BIT);
    hold_line(c3[4], 100);
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk_24m);
    rst = 1'b0;
    asserts++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL t5_busy_after_rst: got %b want 0", rx_busy); end
    asserts++; if (pic_data !== 8'h00) begin fails++; $display("FAIL t5_data_after_rst: got %h want 00", pic_data); end
    hold_line(1'b1, 2 * BIT);
    asserts++; if (rdy_cnt - rb !== 0) begin fails++; $display("FAIL t5_no_c3: got %0d want 0", rdy_cnt - rb); end
    send_frame(8'h12, 1'b1, 1'b0);
    hold_line(1'b1, BIT);
    asserts++; if (rdy_cnt - rb !== 1) begin fails++; $display("FAIL t5_count: got %0d want 1", rdy_cnt - rb); end
    asserts++; if (rx_log.size() <= lb || rx_log[lb] !== 8'h12) begin fails++; $display("FAIL t5_data: log size %0d want 12", rx_log.size()); end
    asserts++; if (fe_cnt - fb !== 0) begin fails++; $display("FAIL t5_ferr: got %0d want 0", fe_cnt - fb); end
  endtask

`ifdef PIC_RX_PARITY_EN
  task automatic test_parity;
    int rb, pb;
    rb = rdy_cnt; pb = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    hold_line(1'b1, BIT);
    asserts++; if (rdy_cnt - rb !== 1) begin fails++; $display("FAIL t6_good_ready: got %0d want 1", rdy_cnt - rb); end
    asserts++; if (pic_data !== 8'h07) begin fails++; $display("FAIL t6_good_data: got %h want 07", pic_data); end
    asserts++; if (pe_cnt - pb !== 0) begin fails++; $display("FAIL t6_good_perr: got %0d want 0", pe_cnt - pb); end
    send_frame(8'h07, 1'b1, 1'b1);
    hold_line(1'b1, BIT);
    asserts++; if (pe_cnt - pb !== 1) begin fails++; $display("FAIL t6_bad_perr: got %0d want 1", pe_cnt - pb); end
    asserts++; if (rdy_cnt - rb !== 1) begin fails++; $display("FAIL t6_bad_ready: got %0d want 1", rdy_cnt - rb); end
  endtask
`endif

  task automatic test_strobe_rules;
    asserts++; if (overlap !== 0) begin fails++; $display("FAIL strobe_overlap: got %0d want 0", overlap); end
    asserts++; if (wide !== 0) begin fails++; $display("FAIL strobe_width: got %0d want 0", wide); end
`ifndef PIC_RX_PARITY_EN
    asserts++; if (pe_cnt !== 0) begin fails++; $display("FAIL parity_tied: got %0d want 0", pe_cnt); end
`endif
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_midframe;
`ifdef PIC_RX_PARITY_EN
    test_parity;
`endif
    test_strobe_rules;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
